// File: rtl/apb_master_ms.sv
// +--------------------------------------------------------------------------+
// | apb_master_ms : single-request APB master, NSLV completers, with timeout |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module apb_master_ms #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NSLV    = 4,
  parameter int SLV_LSB = 12,
  parameter int TIMEOUT = 16
) (
  input  logic                   pclk,
  input  logic                   preset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [DATA_W-1:0]      req_wdata,
  input  logic [DATA_W/8-1:0]    req_strb,
  output logic                   rsp_valid,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   rsp_err,
  output logic [NSLV-1:0]        psel,
  output logic                   penable,
  output logic                   pwrite,
  output logic [ADDR_W-1:0]      paddr,
  output logic [DATA_W-1:0]      pwdata,
  output logic [DATA_W/8-1:0]    pstrb,
  input  logic [NSLV*DATA_W-1:0] prdata_s,
  input  logic [NSLV-1:0]        pready_s,
  input  logic [NSLV-1:0]        pslverr_s
);

  localparam int SEL_W  = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam int STRB_W = DATA_W / 8;
  localparam logic [7:0] c_cnt_last = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DERR   = 2'd3
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [SEL_W-1:0]    r_idx;
  logic [7:0]          r_cnt, w_cnt_nxt;
  logic                r_req_ready, r_rsp_valid, r_rsp_err, r_penable, r_pwrite;
  logic [DATA_W-1:0]   r_rsp_rdata, r_pwdata;
  logic [NSLV-1:0]     r_psel;
  logic [ADDR_W-1:0]   r_paddr;
  logic [STRB_W-1:0]   r_pstrb;

  logic                w_accept, w_idx_ok;
  logic [SEL_W-1:0]    w_req_idx, w_idx_nxt;
  logic                w_sel_ready, w_sel_err;
  logic [DATA_W-1:0]   w_sel_rdata;
  logic                w_rsp_valid_nxt, w_rsp_err_nxt;
  logic [DATA_W-1:0]   w_rsp_rdata_nxt;
  logic [NSLV-1:0]     w_psel_nxt;

  assign w_accept  = req_valid & r_req_ready;
  assign w_req_idx = req_addr[SLV_LSB +: SEL_W];
  assign w_idx_nxt = w_accept ? w_req_idx : r_idx;

  // When NSLV fills the select field every index decodes to a real slave.
  generate
    if (NSLV == (1 << SEL_W)) begin : g_full_decode
      assign w_idx_ok = 1'b1;
    end else begin : g_partial_decode
      localparam logic [SEL_W:0] c_nslv = NSLV[SEL_W:0];
      assign w_idx_ok = ({1'b0, w_req_idx} < c_nslv);
    end
  endgenerate

  always_comb begin
    w_sel_ready = 1'b0;
    w_sel_err   = 1'b0;
    w_sel_rdata = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (r_idx == SEL_W'(i)) begin
        w_sel_ready = pready_s[i];
        w_sel_err   = pslverr_s[i];
        w_sel_rdata = prdata_s[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_err_nxt   = 1'b0;
    w_rsp_rdata_nxt = '0;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_idx_ok) begin
            w_state_nxt = SETUP;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt     = DERR;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_err_nxt   = 1'b1;
          end
        end
      end
      SETUP: w_state_nxt = ACCESS;
      ACCESS: begin
        // A ready in the final allowed cycle wins over the timeout.
        if (w_sel_ready) begin
          w_state_nxt     = IDLE;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = w_sel_err;
          w_rsp_rdata_nxt = r_pwrite ? '0 : w_sel_rdata;
        end else if (r_cnt == c_cnt_last) begin
          w_state_nxt     = IDLE;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      DERR:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase

    w_psel_nxt = '0;
    for (int i = 0; i < NSLV; i++) begin
      w_psel_nxt[i] = ((w_state_nxt == SETUP) || (w_state_nxt == ACCESS)) &&
                      (w_idx_nxt == SEL_W'(i));
    end
  end

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      r_cnt       <= '0;
      r_idx       <= '0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      r_psel      <= '0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_pstrb     <= '0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_req_ready <= (w_state_nxt == IDLE);
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_psel      <= w_psel_nxt;
      r_penable   <= (w_state_nxt == ACCESS);
      if (w_accept) begin
        r_idx    <= w_req_idx;
        r_paddr  <= req_addr;
        r_pwrite <= req_write;
        r_pwdata <= req_write ? req_wdata : '0;
        r_pstrb  <= req_write ? req_strb : '0;
      end
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;
  assign psel      = r_psel;
  assign penable   = r_penable;
  assign pwrite    = r_pwrite;
  assign paddr     = r_paddr;
  assign pwdata    = r_pwdata;
  assign pstrb     = r_pstrb;

endmodule

`default_nettype wire

// File: tb/tb_apb_master_ms.sv
// +--------------------------------------------------------------------------+
// | tb_apb_master_ms : scoreboard bench for apb_master_ms (NSLV = 3)         |
// | Revision         : 1.0                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_apb_master_ms;

  localparam int NSLV = 3;
  localparam int DW   = 32;
  localparam int AW   = 32;
  localparam int TO   = 16;
  localparam int LSB  = 12;

  logic              pclk = 1'b0;
  logic              preset = 1'b0;
  logic              req_valid, req_ready, req_write;
  logic [AW-1:0]     req_addr;
  logic [DW-1:0]     req_wdata;
  logic [DW/8-1:0]   req_strb;
  logic              rsp_valid, rsp_err;
  logic [DW-1:0]     rsp_rdata;
  logic [NSLV-1:0]   psel;
  logic              penable, pwrite;
  logic [AW-1:0]     paddr;
  logic [DW-1:0]     pwdata;
  logic [DW/8-1:0]   pstrb;
  logic [NSLV*DW-1:0] prdata_s;
  logic [NSLV-1:0]   pready_s, pslverr_s;

  apb_master_ms #(
    .ADDR_W(AW), .DATA_W(DW), .NSLV(NSLV), .SLV_LSB(LSB), .TIMEOUT(TO)
  ) dut (
    .pclk(pclk), .preset(preset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb),
    .prdata_s(prdata_s), .pready_s(pready_s), .pslverr_s(pslverr_s)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic            write;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] strb;
    logic [NSLV-1:0] psel;
    int              access;
    int              lat;
    logic            err;
    logic [DW-1:0]   rdata;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;

  int          cur_wait = 0;
  logic        cur_err = 1'b0;
  logic [DW-1:0] cur_rdata = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Reference: what a correct master must produce for one request.
  function automatic exp_t model(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                                 input logic [DW/8-1:0] st, input int wt, input logic er,
                                 input logic [DW-1:0] rd);
    exp_t e;
    int idx;
    idx     = int'(a[LSB +: 2]);
    e.write = w;
    e.addr  = a;
    e.wdata = w ? wd : '0;
    e.strb  = w ? st : '0;
    if (idx >= NSLV) begin
      e.psel = '0; e.access = 0; e.lat = 1; e.err = 1'b1; e.rdata = '0;
    end else begin
      e.psel   = NSLV'(1 << idx);
      e.access = (wt < TO) ? wt + 1 : TO;
      e.lat    = e.access + 2;
      e.err    = (wt < TO) ? er : 1'b1;
      e.rdata  = (w || wt >= TO) ? '0 : rd;
    end
    return e;
  endfunction

  // Completer models: the selected one answers after cur_wait ACCESS cycles, the rest are noise.
  int acc_n = 0;
  always @(negedge pclk) begin
    for (int i = 0; i < NSLV; i++) begin
      pready_s[i]           = 1'($urandom_range(0, 1));
      pslverr_s[i]          = 1'($urandom_range(0, 1));
      prdata_s[i*DW +: DW]  = $urandom;
    end
    if (penable && psel != '0) begin
      for (int i = 0; i < NSLV; i++) begin
        if (psel[i]) begin
          pready_s[i] = (acc_n == cur_wait);
          if (acc_n == cur_wait) begin
            pslverr_s[i]         = cur_err;
            prdata_s[i*DW +: DW] = cur_rdata;
          end
        end
      end
      acc_n++;
    end else begin
      acc_n = 0;
    end
  end

  // Monitor / scoreboard
  int   cyc = 0;
  bit   inflight = 0;
  int   acc_cycle = 0;
  int   nacc = 0;
  bit   bus_bad = 0;
  always @(negedge pclk) begin
    exp_t e;
    cyc++;
    if (!preset) begin
      inflight = 0; nacc = 0; bus_bad = 0;
    end else begin
      if (!inflight && (psel != '0 || penable))
        chk("idle_bus", 64'({psel, penable}), 64'(0));
      if (inflight && q.size() > 0) begin
        e = q[0];
        if (penable && psel != '0) nacc++;
        if (penable && psel == '0) bus_bad = 1;
        if (psel != '0 && (psel !== e.psel || paddr !== e.addr || pwrite !== e.write ||
                           pwdata !== e.wdata || pstrb !== e.strb || rsp_valid))
          bus_bad = 1;
        if ($countones(psel) > 1) bus_bad = 1;
        if (req_ready && !rsp_valid) bus_bad = 1;
      end
      if (rsp_valid) begin
        if (!inflight || q.size() == 0) begin
          chk("unexpected_rsp", 64'(1), 64'(0));
        end else begin
          e = q.pop_front();
          chk("rsp_err", 64'(rsp_err), 64'(e.err));
          chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
          chk("access_cycles", 64'(nacc), 64'(e.access));
          chk("latency", 64'(cyc - acc_cycle), 64'(e.lat));
          chk("bus_stable", 64'(bus_bad), 64'(0));
        end
        inflight = 0;
      end
      if (req_valid && req_ready) begin
        inflight = 1; acc_cycle = cyc; nacc = 0; bus_bad = 0;
      end
    end
  end

  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input logic [DW/8-1:0] st, input int wt, input logic er,
                       input logic [DW-1:0] rd, input bit hold);
    int n;
    n = 0;
    @(posedge pclk); #1;
    while (!req_ready && n < 100) begin
      @(posedge pclk); #1;
      n++;
    end
    if (!req_ready) begin
      chk("ready_wait", 64'(req_ready), 64'(1));
      req_valid = 1'b0;
      return;
    end
    cur_wait  = wt;
    cur_err   = er;
    cur_rdata = rd;
    req_write = w;
    req_addr  = a;
    req_wdata = wd;
    req_strb  = st;
    req_valid = 1'b1;
    q.push_back(model(w, a, wd, st, wt, er, rd));
    @(posedge pclk); #1;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge pclk);
      n++;
    end
    if (q.size() != 0) chk("drain", 64'(q.size()), 64'(0));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] a;
    int wt, sel;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_strb = '0;

    repeat (3) @(posedge pclk);
    #1;
    chk("reset_ctrl", 64'({req_ready, rsp_valid, rsp_err, psel, penable, pwrite, pstrb}), 64'(0));
    chk("reset_data", {rsp_rdata, paddr}, 64'(0));
    chk("reset_pwdata", 64'(pwdata), 64'(0));
    @(negedge pclk) preset = 1'b1;
    @(posedge pclk); #1;
    chk("ready_after_reset", 64'(req_ready), 64'(1));

    issue(1'b1, 32'h0000_2004, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 32'h0, 1'b0);
    issue(1'b0, 32'h0000_1000, 32'h0, 4'hF, 3, 1'b0, 32'h1234_5678, 1'b0);
    issue(1'b0, 32'h0000_0040, 32'h0, 4'h0, 100, 1'b0, 32'h5555_AAAA, 1'b0);
    issue(1'b1, 32'h0000_3000, 32'h1, 4'h3, 0, 1'b0, 32'h0, 1'b0);
    issue(1'b1, 32'h0000_0010, 32'hCAFE_F00D, 4'h5, 2, 1'b1, 32'h0, 1'b1);
    issue(1'b1, 32'h0000_0010, 32'hCAFE_F00D, 4'h5, 2, 1'b1, 32'h0, 1'b0);
    issue(1'b0, 32'h0000_1ABC, 32'h0, 4'h0, 15, 1'b0, 32'h0BAD_CAFE, 1'b0);
    issue(1'b0, 32'h0000_2ABC, 32'h0, 4'h0, 14, 1'b1, 32'h7777_1111, 1'b0);

    for (int k = 0; k < 60; k++) begin
      a = $urandom;
      a[LSB +: 2] = 2'($urandom_range(0, 3));
      sel = $urandom_range(0, 9);
      wt  = (sel < 7) ? $urandom_range(0, 4) : (sel == 7) ? 14 : (sel == 8) ? 15 : 20;
      issue(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), wt,
            1'($urandom_range(0, 1)), $urandom, (k != 59) && ($urandom_range(0, 3) == 0));
    end
    drain();

    // Abort a transfer mid-ACCESS.
    issue(1'b0, 32'h0000_2000, 32'h0, 4'h0, 100, 1'b0, 32'h0, 1'b0);
    repeat (3) @(posedge pclk);
    #1;
    chk("pre_reset_access", 64'(penable), 64'(1));
    #1 preset = 1'b0;
    #1;
    chk("abort_ctrl", 64'({req_ready, rsp_valid, rsp_err, psel, penable, pwrite, pstrb}), 64'(0));
    chk("abort_data", {rsp_rdata, paddr}, 64'(0));
    q.delete();
    repeat (2) @(negedge pclk);
    preset = 1'b1;
    @(posedge pclk); #1;
    chk("ready_after_abort", 64'(req_ready), 64'(1));
    repeat (4) @(posedge pclk);

    issue(1'b0, 32'h0000_1004, 32'h0, 4'h0, 1, 1'b0, 32'hA5A5_5A5A, 1'b0);
    drain();
    repeat (3) @(posedge pclk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/apb_master_ms.md
APB_MASTER_MS -- requirements
Module: apb_master_ms

Interface
REQ-001 Parameter ADDR_W, default 32, address width of the request and paddr.
REQ-002 Parameter DATA_W, default 32, data width; SHALL be 8, 16 or 32.
REQ-003 Parameter NSLV, default 4, number of APB completers; range 1..8.
REQ-004 Parameter SLV_LSB, default 12, lowest paddr bit of the slave-select field; field width SEL_W = max(1, clog2(NSLV)).
REQ-005 Parameter TIMEOUT, default 16, maximum ACCESS cycles before forced termination; range 2..255.
REQ-006 pclk  in  1  the only clock; all state updates on the rising edge.
REQ-007 preset  in  1  reset, asynchronous, active-low.
REQ-008 req_valid  in  1  request present.
REQ-009 req_ready  out  1  master can accept a request.
REQ-010 req_write  in  1  1 = write, 0 = read.
REQ-011 req_addr  in  ADDR_W  byte address.
REQ-012 req_wdata  in  DATA_W  write data.
REQ-013 req_strb  in  DATA_W/8  write byte strobes.
REQ-014 rsp_valid  out  1  one-cycle completion pulse.
REQ-015 rsp_rdata  out  DATA_W  read data; 0 on writes and errors.
REQ-016 rsp_err  out  1  slave error, decode error or timeout.
REQ-017 psel  out  NSLV  one-hot completer select.
REQ-018 penable, pwrite  out  1 each  APB access phase and direction.
REQ-019 paddr  out  ADDR_W;  pwdata  out  DATA_W;  pstrb  out  DATA_W/8.
REQ-020 prdata_s  in  NSLV*DATA_W  read data; slave i in bits [i*DATA_W +: DATA_W].
REQ-021 pready_s, pslverr_s  in  NSLV each  per-slave ready and error.

Function
REQ-022 States: IDLE, SETUP, ACCESS, DERR.
REQ-023 All outputs are registered.
REQ-024 req_ready is 1 only in IDLE; a request is accepted when req_valid and req_ready are both 1 on a clock edge.
REQ-025 On acceptance, capture addr, wdata, strb and write; compute idx = req_addr[SLV_LSB +: SEL_W].
REQ-026 If idx < NSLV, go to SETUP; if idx >= NSLV, go to DERR.
REQ-027 SETUP, one cycle: psel[idx] = 1, penable = 0, with paddr, pwrite, pwdata and pstrb driven from the captured request; then go to ACCESS.
REQ-028 ACCESS: psel[idx] = 1, penable = 1, all address and control held stable.
REQ-029 ACCESS completes on the cycle pready_s[idx] = 1; only the selected slave's pready, pslverr and prdata are observed.
REQ-030 On completion, go to IDLE and pulse rsp_valid for one cycle; rsp_err = pslverr_s[idx]; rsp_rdata = prdata_s[idx] for a read, else 0.
REQ-031 Timeout counter clears on SETUP entry and increments each ACCESS cycle without pready.
REQ-032 If the counter reaches TIMEOUT, go to IDLE with rsp_valid = 1, rsp_err = 1, rsp_rdata = 0; pready arriving in that same cycle takes precedence over timeout.
REQ-033 DERR, one cycle: no psel asserted; rsp_valid = 1, rsp_err = 1, rsp_rdata = 0; then go to IDLE.
REQ-034 For reads, pstrb = 0 and pwdata = 0.
REQ-035 psel and penable are 0 in IDLE; at most one psel bit is ever 1.
REQ-036 Minimum transfer spacing: acceptance, SETUP, ACCESS, then the next acceptance no earlier than 3 cycles after the previous one.
REQ-037 rsp_valid is never stalled; the requester always accepts it.

Reset
REQ-038 While preset = 0, go asynchronously to IDLE with every output 0 (req_ready becomes 1 after release) and the counter cleared.
REQ-039 Reset during SETUP or ACCESS aborts the transfer with no rsp_valid.

Verification
REQ-040 Write 0x0000_2004 / 0xDEADBEEF / strb 0xF, slave 2 ready in the first ACCESS cycle -> psel = 0100 in SETUP and ACCESS, pwdata = 0xDEADBEEF, rsp_valid with rsp_err = 0 and rsp_rdata = 0.
REQ-041 Read 0x0000_1000, slave 1 holds pready low for 3 cycles then returns 0x1234_5678 -> 4 ACCESS cycles, address stable throughout, rsp_rdata = 0x1234_5678.
REQ-042 Read to slave 0 with pready never asserted, TIMEOUT = 16 -> exactly 16 ACCESS cycles, then rsp_err = 1, rsp_rdata = 0, psel = 0.
REQ-043 NSLV = 3 with a request to address 0x0000_3000 -> no psel, DERR, rsp_err = 1 on the cycle after acceptance.
REQ-044 Write with pslverr_s[0] = 1 at pready -> rsp_err = 1; a back-to-back second request is accepted only once back in IDLE.
REQ-045 preset asserted mid-ACCESS -> outputs 0 immediately, no rsp_valid, req_ready = 1 on the first edge after release.
